// File: rtl/ivs_dma_rsp.sv
// ivs_dma_rsp - responder side of the IVS DMA round-robin arbiter handshake.
//
// On an arbiter request the granted channel's descriptor (start byte address,
// length in beats) is latched. The transfer is split into read bursts of at
// most MAX_BURST beats, with one burst in flight at a time. Returned data is
// passed through combinationally to the consumer, tagged with the channel id.
// A one-cycle resp pulse marks completion and releases the arbiter.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   comreq           arbiter request (level, held until the cycle after resp)
//   grant_i          granted channel index, valid while comreq=1
//   desc_addr_i      per-channel start byte address, channel 0 in the LSBs
//   desc_len_i       per-channel length in beats, channel 0 in the LSBs
//   resp             one-cycle transfer-done pulse
//   err_o            one-cycle pulse with resp when the grant was out of range
//   busy_o           high whenever a transfer is in progress
//   rd_cmd_*         memory read command (valid/ready, byte address, beats-1)
//   rd_dat_*         memory read data (valid/ready, data)
//   out_*            consumer stream (valid/ready, data, channel id, last beat)
module ivs_dma_rsp #(
  parameter int NCH       = 4,
  parameter int IDW       = 2,
  parameter int AW        = 32,
  parameter int DW        = 64,
  parameter int LW        = 16,
  parameter int MAX_BURST = 16,
  parameter int BLW       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              comreq,
  input  logic [IDW-1:0]    grant_i,
  input  logic [NCH*AW-1:0] desc_addr_i,
  input  logic [NCH*LW-1:0] desc_len_i,
  output logic              resp,
  output logic              err_o,
  output logic              busy_o,
  output logic              rd_cmd_valid,
  input  logic              rd_cmd_ready,
  output logic [AW-1:0]     rd_cmd_addr,
  output logic [BLW-1:0]    rd_cmd_len,
  input  logic              rd_dat_valid,
  output logic              rd_dat_ready,
  input  logic [DW-1:0]     rd_dat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [IDW-1:0]    out_id,
  output logic              out_last
);

  localparam int            BYTES_PER_BEAT = DW / 8;
  localparam logic [BLW:0]  MAXB           = (BLW+1)'(MAX_BURST);
  localparam logic [BLW:0]  BONE           = (BLW+1)'(1);

  typedef enum logic [1:0] {IDLE, CMD, DATA, RESP} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] cur_id;
  logic [AW-1:0]  cur_addr;
  logic [LW-1:0]  remaining;
  logic [BLW:0]   beat_cnt;
  logic           err_flag;

  // Descriptor of the granted channel; an out-of-range grant selects nothing.
  logic [AW-1:0]  sel_addr;
  logic [LW-1:0]  sel_len;
  logic           sel_ok;

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    sel_ok   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (grant_i == IDW'(i)) begin
        sel_addr = desc_addr_i[i*AW +: AW];
        sel_len  = desc_len_i[i*LW +: LW];
        sel_ok   = 1'b1;
      end
    end
  end

  // Beats in the next burst: whatever is left, capped at MAX_BURST.
  logic [BLW:0] burst;
  assign burst = (remaining >= LW'(MAX_BURST)) ? MAXB : (BLW+1)'(remaining);

  logic beat;
  assign beat = (state == DATA) && rd_dat_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_id    <= '0;
      cur_addr  <= '0;
      remaining <= '0;
      beat_cnt  <= '0;
      err_flag  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (comreq) begin
            cur_id    <= grant_i;
            cur_addr  <= sel_addr;
            remaining <= sel_len;
            beat_cnt  <= '0;
            err_flag  <= !sel_ok;
          end
        end
        CMD: begin
          if (rd_cmd_ready) begin
            beat_cnt  <= burst;
            remaining <= remaining - LW'(burst);
            // Address arithmetic wraps modulo 2^AW.
            cur_addr  <= cur_addr + AW'(burst) * AW'(BYTES_PER_BEAT);
          end
        end
        DATA: begin
          if (beat) beat_cnt <= beat_cnt - BONE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt    = state;
    resp         = 1'b0;
    err_o        = 1'b0;
    rd_cmd_valid = 1'b0;
    rd_cmd_addr  = '0;
    rd_cmd_len   = '0;
    rd_dat_ready = 1'b0;
    out_valid    = 1'b0;
    out_data     = '0;
    out_last     = 1'b0;
    case (state)
      IDLE: begin
        // Zero-length and out-of-range grants skip straight to the response.
        if (comreq) state_nxt = (!sel_ok || sel_len == '0) ? RESP : CMD;
      end
      CMD: begin
        rd_cmd_valid = 1'b1;
        rd_cmd_addr  = cur_addr;
        rd_cmd_len   = BLW'(burst - BONE);
        if (rd_cmd_ready) state_nxt = DATA;
      end
      DATA: begin
        // Pure pass-through: memory and consumer see each other's handshake.
        out_valid    = rd_dat_valid;
        rd_dat_ready = out_ready;
        out_data     = rd_dat;
        out_last     = (beat_cnt == BONE) && (remaining == '0);
        if (beat && beat_cnt == BONE) state_nxt = (remaining != '0) ? CMD : RESP;
      end
      RESP: begin
        resp      = 1'b1;
        err_o     = err_flag;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o = (state != IDLE);
  assign out_id = cur_id;

endmodule

// File: tb/tb_ivs_dma_rsp.sv
// tb_ivs_dma_rsp - directed bench for ivs_dma_rsp.
// A table of transfers is replayed through a small memory/consumer model,
// followed by hand-written sequences for the invalid grant (NCH=3 instance),
// reset in the middle of a burst and a round-robin series of transfers.
module tb_ivs_dma_rsp;
  localparam int NCH = 4;
  localparam int IDW = 2;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int LW  = 16;
  localparam int BLW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              comreq = 1'b0;
  logic [IDW-1:0]    grant_i = '0;
  logic [NCH*AW-1:0] desc_addr_i;
  logic [NCH*LW-1:0] desc_len_i;
  logic              resp, err_o, busy_o;
  logic              rd_cmd_valid;
  logic              rd_cmd_ready = 1'b1;
  logic [AW-1:0]     rd_cmd_addr;
  logic [BLW-1:0]    rd_cmd_len;
  logic              rd_dat_valid = 1'b0;
  logic              rd_dat_ready;
  logic [DW-1:0]     rd_dat = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DW-1:0]     out_data;
  logic [IDW-1:0]    out_id;
  logic              out_last;

  ivs_dma_rsp dut (
    .clk(clk), .rst_n(rst_n), .comreq(comreq), .grant_i(grant_i),
    .desc_addr_i(desc_addr_i), .desc_len_i(desc_len_i),
    .resp(resp), .err_o(err_o), .busy_o(busy_o),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
    .rd_cmd_addr(rd_cmd_addr), .rd_cmd_len(rd_cmd_len),
    .rd_dat_valid(rd_dat_valid), .rd_dat_ready(rd_dat_ready), .rd_dat(rd_dat),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .out_last(out_last)
  );

  // Three-channel instance, used for the out-of-range grant.
  logic            comreq2 = 1'b0;
  logic [1:0]      grant2 = '0;
  logic [3*AW-1:0] daddr2 = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
  logic [3*LW-1:0] dlen2  = {16'd5, 16'd5, 16'd5};
  logic            resp2, err2, busy2, cv2, dr2, ov2, ol2;
  logic [AW-1:0]   ca2;
  logic [BLW-1:0]  cl2;
  logic [DW-1:0]   od2;
  logic [1:0]      oid2;

  ivs_dma_rsp #(.NCH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .comreq(comreq2), .grant_i(grant2),
    .desc_addr_i(daddr2), .desc_len_i(dlen2),
    .resp(resp2), .err_o(err2), .busy_o(busy2),
    .rd_cmd_valid(cv2), .rd_cmd_ready(1'b1), .rd_cmd_addr(ca2), .rd_cmd_len(cl2),
    .rd_dat_valid(1'b0), .rd_dat_ready(dr2), .rd_dat(64'd0),
    .out_valid(ov2), .out_ready(1'b1), .out_data(od2), .out_id(oid2), .out_last(ol2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_desc(input int ch, input logic [31:0] a, input int l);
    desc_addr_i[ch*AW +: AW] = a;
    desc_len_i[ch*LW +: LW]  = LW'(l);
  endtask

  // Results of the most recent run_xfer.
  int          x_ncmd, x_nbeat, x_nresp, x_resp_cyc, x_last_len;
  logic [31:0] x_last_addr;

  // One full transfer: the bench plays memory (one burst answered after each
  // accepted command) and consumer (out_ready pattern). After the first cycle
  // the grant and the channel's descriptor are scrambled; the DUT must ignore that.
  task automatic run_xfer(input int ch, input logic [31:0] base, input int len,
                          input int out_pat, input int stall, input logic exp_err);
    int cyc, pend, rem, stall_left, burst;
    logic [31:0] eaddr;
    logic [AW-1:0] hold_addr;
    logic [BLW-1:0] hold_len;
    logic held;
    bit done;
    x_ncmd = 0; x_nbeat = 0; x_nresp = 0; x_resp_cyc = -1; x_last_len = -1; x_last_addr = '0;
    rem = len; eaddr = base; pend = 0; stall_left = stall; held = 1'b0; done = 1'b0; cyc = 0;
    hold_addr = '0; hold_len = '0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      comreq = 1'b1;
      if (cyc == 0) begin
        grant_i = IDW'(ch);
        set_desc(ch, base, len);
      end else begin
        grant_i = IDW'(ch + 1);
        set_desc(ch, 32'hDEAD_BEE0, 9);
      end
      if (rd_cmd_valid && stall_left > 0) begin
        rd_cmd_ready = 1'b0;
        stall_left--;
      end else begin
        rd_cmd_ready = 1'b1;
      end
      rd_dat_valid = (pend > 0);
      rd_dat       = {32'hC0DE_0000 + 32'(ch), 32'(x_nbeat)};
      out_ready    = (out_pat == 1) ? (cyc % 2 == 0) : 1'b1;
      #1;
      if (rd_cmd_valid) begin
        check("cmd_while_burst_pending", 64'(pend), 64'd0);
        if (held) begin
          check("cmd_addr_stable", rd_cmd_addr, hold_addr);
          check("cmd_len_stable", rd_cmd_len, hold_len);
        end
        hold_addr = rd_cmd_addr;
        hold_len  = rd_cmd_len;
        held      = !rd_cmd_ready;
        if (rd_cmd_ready) begin
          burst = (rem > 16) ? 16 : rem;
          check("cmd_addr", rd_cmd_addr, eaddr);
          check("cmd_len", rd_cmd_len, 64'(burst - 1));
          x_last_addr = rd_cmd_addr;
          x_last_len  = int'(rd_cmd_len);
          x_ncmd++;
          pend  = burst;
          rem   = rem - burst;
          eaddr = eaddr + 32'(burst * 8);
        end
      end
      if (rd_dat_valid) begin
        check("out_valid", out_valid, 1'b1);
        check("rd_dat_ready_tracks", rd_dat_ready, out_ready);
        check("out_data", out_data, rd_dat);
      end else begin
        check("out_valid_idle", out_valid, 1'b0);
      end
      if (rd_dat_valid && out_ready) begin
        x_nbeat++;
        pend--;
        check("out_id", out_id, 64'(ch));
        check("out_last", out_last, (x_nbeat == len));
      end
      if (resp) begin
        x_nresp++;
        x_resp_cyc = cyc;
        check("resp_err", err_o, exp_err);
        check("resp_beats", 64'(x_nbeat), 64'(len));
        done = 1'b1;
      end
      cyc++;
    end
    if (!done) check("resp_timeout", 64'd0, 64'd1);
    // Arbiter drops comreq on the edge that ends the response cycle.
    @(negedge clk);
    comreq       = 1'b0;
    rd_dat_valid = 1'b0;
    rd_cmd_ready = 1'b1;
    out_ready    = 1'b1;
    #1;
    check("resp_single_pulse", resp, 1'b0);
    check("idle_after_resp", busy_o, 1'b0);
  endtask

  typedef struct {
    int          ch;
    logic [31:0] base;
    int          len;
    int          out_pat;
    int          stall;
    int          exp_ncmd;
    logic [31:0] exp_last_addr;
    int          exp_last_len;
    int          exp_resp_cyc;   // -1: not checked
  } vec_t;

  vec_t vt[7];
  int   rr_order[4];

  initial begin
    for (int i = 0; i < NCH; i++) set_desc(i, 32'hBAD0_0000 + 32'(i * 256), 11);

    vt[0] = '{1, 32'h0000_1000,  3, 0, 0, 1, 32'h0000_1000,  2,  5};
    vt[1] = '{2, 32'h0000_0000, 40, 0, 0, 3, 32'h0000_0100,  7, 44};
    vt[2] = '{0, 32'h0000_0500,  0, 0, 0, 0, 32'h0000_0000,  0,  1};
    vt[3] = '{3, 32'h0000_2000,  4, 1, 5, 1, 32'h0000_2000,  3, -1};
    vt[4] = '{0, 32'hFFFF_FFC0, 20, 0, 0, 2, 32'h0000_0040,  3, 23};
    vt[5] = '{1, 32'h0000_0800, 32, 0, 0, 2, 32'h0000_0880, 15, 35};
    vt[6] = '{3, 32'hFFFF_FFF8,  1, 0, 0, 1, 32'hFFFF_FFF8,  0,  3};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_resp", resp, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_cmd_valid", rd_cmd_valid, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_rd_dat_ready", rd_dat_ready, 1'b0);
    check("rst_out_id", out_id, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      run_xfer(vt[v].ch, vt[v].base, vt[v].len, vt[v].out_pat, vt[v].stall, 1'b0);
      check($sformatf("v%0d_ncmd", v), 64'(x_ncmd), 64'(vt[v].exp_ncmd));
      check($sformatf("v%0d_nresp", v), 64'(x_nresp), 64'd1);
      if (vt[v].exp_ncmd > 0) begin
        check($sformatf("v%0d_last_cmd_addr", v), x_last_addr, vt[v].exp_last_addr);
        check($sformatf("v%0d_last_cmd_len", v), 64'(x_last_len), 64'(vt[v].exp_last_len));
      end
      if (vt[v].exp_resp_cyc >= 0)
        check($sformatf("v%0d_resp_latency", v), 64'(x_resp_cyc), 64'(vt[v].exp_resp_cyc));
    end

    // Out-of-range grant on the three-channel instance
    @(negedge clk);
    comreq2 = 1'b1;
    grant2  = 2'd3;
    #1;
    check("err_idle_resp", resp2, 1'b0);
    @(negedge clk);
    #1;
    check("err_resp", resp2, 1'b1);
    check("err_flag", err2, 1'b1);
    check("err_no_cmd", cv2, 1'b0);
    @(negedge clk);
    comreq2 = 1'b0;
    #1;
    check("err_resp_drop", resp2, 1'b0);
    check("err_flag_drop", err2, 1'b0);
    check("err_idle", busy2, 1'b0);

    // Reset in the middle of a 16-beat burst
    set_desc(2, 32'h0000_3000, 16);
    @(negedge clk);
    comreq = 1'b1;
    grant_i = 2'd2;
    rd_cmd_ready = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);            // CMD, accepted at the next edge
    @(negedge clk);
    rd_dat_valid = 1'b1;
    rd_dat = 64'h1234;
    repeat (4) @(negedge clk);
    #1;
    check("mid_busy", busy_o, 1'b1);
    check("mid_out_valid", out_valid, 1'b1);
    check("mid_out_id", out_id, 64'd2);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy_o, 1'b0);
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_rd_dat_ready", rd_dat_ready, 1'b0);
    check("arst_out_last", out_last, 1'b0);
    check("arst_cmd_valid", rd_cmd_valid, 1'b0);
    check("arst_resp", resp, 1'b0);
    check("arst_out_id", out_id, 64'd0);
    check("arst_out_data", out_data, 64'd0);
    comreq = 1'b0;
    rd_dat_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_xfer(1, 32'h0000_1000, 3, 0, 0, 1'b0);
    check("post_rst_ncmd", 64'(x_ncmd), 64'd1);
    check("post_rst_addr", x_last_addr, 32'h0000_1000);
    check("post_rst_len", 64'(x_last_len), 64'd2);
    check("post_rst_resp_latency", 64'(x_resp_cyc), 64'd5);

    // Round-robin series: all four channels requesting, two beats each
    rr_order[0] = 1; rr_order[1] = 2; rr_order[2] = 3; rr_order[3] = 0;
    for (int k = 0; k < 4; k++) begin
      run_xfer(rr_order[k], 32'h0000_4000 + 32'(k * 256), 2, 0, 0, 1'b0);
      check($sformatf("rr%0d_nresp", k), 64'(x_nresp), 64'd1);
      check($sformatf("rr%0d_nbeat", k), 64'(x_nbeat), 64'd2);
      check($sformatf("rr%0d_resp_latency", k), 64'(x_resp_cyc), 64'd4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
